// File: rtl/dot_channel_feeder_pkg.sv
// Shared widths, state encoding and result payload for the dot-channel feeder family.
package dot_channel_feeder_pkg;

  localparam int unsigned DATA_LEN  = 16;
  localparam int unsigned DC_ROWS   = 6;
  localparam int unsigned DC_WORDS  = 36;
  localparam int unsigned ROW_W     = DC_ROWS * DATA_LEN;
  localparam int unsigned VEC_W     = DC_WORDS * DATA_LEN;
  localparam int unsigned CS_W      = 4;
  localparam int unsigned ROW_CNT_W = 3;
  localparam int unsigned PHASE_W   = 3;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } dc_state_e;

  typedef struct packed {
    logic [DATA_LEN-1:0] data;
    logic [CS_W-1:0]     cs;
    logic                last;
  } dc_result_t;

endpackage

// File: rtl/dot_channel_feeder_dc_row_packer.sv
// Packs six accepted activation rows into one 36-word vector and latches the
// vector phase on the first beat; full_c_o pulses on the beat that completes it.
module dc_row_packer
  import dot_channel_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  input  logic               in_ready_i,
  input  logic [ROW_W-1:0]   in_row_i,
  input  logic [PHASE_W-1:0] in_phase_i,
  output logic [VEC_W-1:0]   vec_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               full_c_o
);

  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 accept;

  // Row write, phase latch and row counter with explicit 5->0 wrap.
  always_comb begin
    accept    = in_valid_i && in_ready_i;
    row_cnt_d = row_cnt_q;
    vec_d     = vec_q;
    phase_d   = phase_q;
    full_c_o  = 1'b0;
    if (accept) begin
      for (int unsigned k = 0; k < DC_ROWS; k++) begin
        if (row_cnt_q == ROW_CNT_W'(k)) begin
          vec_d[k*ROW_W +: ROW_W] = in_row_i;
        end
      end
      if (row_cnt_q == '0) begin
        phase_d = in_phase_i;
      end
      if (row_cnt_q == ROW_CNT_W'(DC_ROWS - 1)) begin
        row_cnt_d = '0;
        full_c_o  = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q <= '0;
      vec_q     <= '0;
      phase_q   <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      vec_q     <= vec_d;
      phase_q   <= phase_d;
    end
  end

  assign vec_o   = vec_q;
  assign phase_o = phase_q;

endmodule

// File: rtl/dot_channel_feeder.sv
// Transmit side of the dot-channel interface: fills a vector, sweeps cs 0..CS_NUM-1
// through one dot channel and forwards each tagged result downstream.
// Optional feature macro: DC_FEEDER_TIMEOUT_EN (ISSUE timeout with sticky err).
module dot_channel_feeder
  import dot_channel_feeder_pkg::*;
#(
  parameter int unsigned CS_NUM  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROW_W-1:0]    in_row,
  input  logic [PHASE_W-1:0]  in_phase,
  output logic [VEC_W-1:0]    dc_d,
  output logic                dc_load,
  output logic                ws_load,
  output logic [CS_W-1:0]     dc_cs,
  output logic [PHASE_W-1:0]  dc_phase,
  input  logic                dc_valid,
  input  logic [DATA_LEN-1:0] dc_q,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_LEN-1:0] res_data,
  output logic [CS_W-1:0]     res_cs,
  output logic                res_last,
  output logic                err
);

  dc_state_e           state_q, state_d;
  logic [CS_W-1:0]     cs_cnt_q, cs_cnt_d;
  dc_result_t          res_q, res_d;
  logic                res_valid_q, res_valid_d;
  logic                load_q, load_d;
  logic                in_ready_q, in_ready_d;
  logic                full_c;
  logic                capture;
  logic [DATA_LEN-1:0] cap_data;

`ifdef DC_FEEDER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
`endif

  dc_row_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_i (in_ready_q),
    .in_row_i   (in_row),
    .in_phase_i (in_phase),
    .vec_o      (dc_d),
    .phase_o    (dc_phase),
    .full_c_o   (full_c)
  );

  // Sweep FSM: next state, cs sequencing, result capture and registered strobes.
  always_comb begin
    state_d     = state_q;
    cs_cnt_d    = cs_cnt_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    capture     = 1'b0;
    cap_data    = '0;
`ifdef DC_FEEDER_TIMEOUT_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_FILL: begin
        if (full_c) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dc_valid) begin
          capture  = 1'b1;
          cap_data = dc_q;
        end
`ifdef DC_FEEDER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          capture  = 1'b1;
          cap_data = '0;
          err_d    = 1'b1;
        end
`endif
        if (capture) begin
          res_d.data  = cap_data;
          res_d.cs    = cs_cnt_q;
          res_d.last  = (cs_cnt_q == CS_W'(CS_NUM - 1));
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (res_q.last) begin
            cs_cnt_d = '0;
            state_d  = ST_FILL;
          end else begin
            cs_cnt_d = cs_cnt_q + CS_W'(1);
            state_d  = ST_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
    // Loads drop for at least the cycle the result is presented, re-arming the channel.
    load_d     = (state_d == ST_ISSUE);
    in_ready_d = (state_d == ST_FILL);
  end

`ifdef DC_FEEDER_TIMEOUT_EN
  // Cycles spent waiting in ISSUE for the current cs.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_ISSUE && state_d == ST_ISSUE) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  // Without the timeout the channel is waited on indefinitely and err never sets.
  assign err = 1'b0 & (TIMEOUT == 0);
`endif

  // FSM state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      cs_cnt_q    <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      load_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cs_cnt_q    <= cs_cnt_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      load_q      <= load_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign dc_load   = load_q;
  assign ws_load   = load_q;
  assign dc_cs     = cs_cnt_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q.data;
  assign res_cs    = res_q.cs;
  assign res_last  = res_q.last;

endmodule

// File: tb/tb_dot_channel_feeder.sv
// Self-checking bench for dot_channel_feeder with a model dot channel and result scoreboard.
module tb_dot_channel_feeder;
  import dot_channel_feeder_pkg::*;

  localparam int DW  = DATA_LEN;
  localparam int NCS = 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [ROW_W-1:0]    in_row;
  logic [PHASE_W-1:0]  in_phase;
  logic [VEC_W-1:0]    dc_d;
  logic                dc_load;
  logic                ws_load;
  logic [CS_W-1:0]     dc_cs;
  logic [PHASE_W-1:0]  dc_phase;
  logic                dc_valid;
  logic [DW-1:0]       dc_q;
  logic                res_valid;
  logic                res_ready;
  logic [DW-1:0]       res_data;
  logic [CS_W-1:0]     res_cs;
  logic                res_last;
  logic                err;

  int checks = 0;
  int errors = 0;
  int mute_cs = -1;
  logic [3:0] ch_cnt;
  dc_result_t sb[$];

  always #5 clk = ~clk;

  dot_channel_feeder #(.CS_NUM(NCS), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_phase(in_phase), .dc_d(dc_d), .dc_load(dc_load), .ws_load(ws_load), .dc_cs(dc_cs),
    .dc_phase(dc_phase), .dc_valid(dc_valid), .dc_q(dc_q), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_cs(res_cs), .res_last(res_last), .err(err)
  );

  // Model channel: valid on the third cycle of dc_load, q = cs*2+1; mute_cs never answers.
  always @(posedge clk or posedge rst) begin
    if (rst) ch_cnt <= 4'd0;
    else if (!dc_load) ch_cnt <= 4'd0;
    else ch_cnt <= ch_cnt + 4'd1;
  end

  always_comb begin
    dc_valid = dc_load && (ch_cnt == 4'd2) && (int'(dc_cs) != mute_cs);
    dc_q     = dc_valid ? DW'(int'(dc_cs) * 2 + 1) : DW'(16'hDEAD);
  end

  task automatic push_sweep(input int skip_cs);
    for (int c = 0; c < NCS; c++) begin
      dc_result_t e;
      e.data = (c == skip_cs) ? DW'(0) : DW'(c * 2 + 1);
      e.cs   = CS_W'(c);
      e.last = (c == NCS - 1);
      sb.push_back(e);
    end
  endtask

  // Drives six beats starting at a negedge; returns at the negedge after the last accept.
  task automatic send_vector(input int seed, input logic [2:0] ph, input bit keep_valid,
                             output logic [VEC_W-1:0] exp_vec, output logic load_before);
    logic [ROW_W-1:0] row;
    exp_vec = '0;
    load_before = 1'b0;
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      for (int w = 0; w < 6; w++) row[w*DW +: DW] = DW'(seed * 256 + k * 16 + w);
      exp_vec[k*ROW_W +: ROW_W] = row;
      in_row   = row;
      in_phase = (k == 0) ? ph : ~ph;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        errors++;
        $display("FAIL in_ready_wait beat %0d got in_ready=%0b exp 1", k, in_ready);
      end
      if (k == 5) load_before = dc_load;
      @(negedge clk);
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Collects n results, checking against the scoreboard; optional stall on one cs.
  task automatic collect(input int n, input int stall_cs, input int stall_len, output int mute_cycles);
    int got = 0, waited = 0, stalled = 0, early = 0;
    logic [DW-1:0] s_data;
    logic [3:0]    s_cs;
    logic          s_last;
    dc_result_t    e;
    mute_cycles = 0;
    res_ready = 1'b1;
    while (got < n && waited < 2000) begin
      @(negedge clk);
      waited++;
      if (in_valid && in_ready) early++;
      if (dc_load && int'(dc_cs) == mute_cs) mute_cycles++;
      if (res_valid) begin
        checks++;
        if (dc_load !== 1'b0) begin
          errors++;
          $display("FAIL load_gap cs %0d got dc_load=%0b exp 0", res_cs, dc_load);
        end
        if (int'(res_cs) == stall_cs && stalled < stall_len) begin
          if (stalled == 0) begin
            s_data = res_data; s_cs = res_cs; s_last = res_last;
          end else begin
            checks++;
            if ({res_data, res_cs, res_last} !== {s_data, s_cs, s_last}) begin
              errors++;
              $display("FAIL stall_stable got %0h/%0d/%0b exp %0h/%0d/%0b",
                       res_data, res_cs, res_last, s_data, s_cs, s_last);
            end
          end
          res_ready = 1'b0;
          stalled++;
        end else begin
          res_ready = 1'b1;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty got cs %0d data %0h exp no result", res_cs, res_data);
          end else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_cs !== e.cs || res_last !== e.last) begin
              errors++;
              $display("FAIL result got data %0h cs %0d last %0b exp data %0h cs %0d last %0b",
                       res_data, res_cs, res_last, e.data, e.cs, e.last);
            end
          end
          got++;
        end
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL collect_timeout got %0d results exp %0d", got, n);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL early_accept got %0d beats accepted mid-sweep exp 0", early);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_row = '0; in_phase = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    checks++; if (dc_load !== 1'b0) begin errors++; $display("FAIL rst_dc_load got %0b exp 0", dc_load); end
    checks++; if (ws_load !== 1'b0) begin errors++; $display("FAIL rst_ws_load got %0b exp 0", ws_load); end
    checks++; if (dc_cs !== 4'd0) begin errors++; $display("FAIL rst_dc_cs got %0d exp 0", dc_cs); end
    checks++; if (dc_phase !== 3'd0) begin errors++; $display("FAIL rst_dc_phase got %0d exp 0", dc_phase); end
    checks++; if (dc_d !== '0) begin errors++; $display("FAIL rst_dc_d got nonzero exp 0"); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %0b exp 0", res_valid); end
    checks++; if ({res_data, res_cs, res_last} !== '0) begin
      errors++; $display("FAIL rst_res got %0h/%0d/%0b exp 0", res_data, res_cs, res_last); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err); end
  endtask

  task automatic test_fill_and_sweep();
    logic [VEC_W-1:0] v;
    logic lb;
    int mc;
    send_vector(1, 3'd3, 1'b0, v, lb);
    checks++; if (lb !== 1'b0) begin errors++; $display("FAIL fill_load_early got %0b exp 0", lb); end
    checks++; if (dc_load !== 1'b1 || ws_load !== 1'b1) begin
      errors++; $display("FAIL fill_load_rise got %0b/%0b exp 1/1", dc_load, ws_load); end
    checks++; if (dc_d !== v) begin errors++; $display("FAIL fill_dc_d got %0h exp %0h", dc_d, v); end
    checks++; if (dc_phase !== 3'd3) begin errors++; $display("FAIL fill_phase got %0d exp 3", dc_phase); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0b exp 0", in_ready); end
    checks++; if (dc_cs !== 4'd0) begin errors++; $display("FAIL fill_cs got %0d exp 0", dc_cs); end
    push_sweep(-1);
    collect(NCS, -1, 0, mc);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || dc_d !== v) begin
      errors++; $display("FAIL sweep_end in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [VEC_W-1:0] v;
    logic lb;
    int mc;
    send_vector(2, 3'd5, 1'b0, v, lb);
    push_sweep(-1);
    collect(NCS, 4, 5, mc);
    checks++; if (dc_phase !== 3'd5) begin errors++; $display("FAIL bp_phase got %0d exp 5", dc_phase); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [VEC_W-1:0] v;
    logic lb;
    int mc;
    send_vector(3, 3'd1, 1'b1, v, lb);
    push_sweep(-1);
    collect(NCS, -1, 0, mc);
    send_vector(4, 3'd6, 1'b0, v, lb);
    checks++; if (dc_d !== v) begin errors++; $display("FAIL b2b_dc_d got %0h exp %0h", dc_d, v); end
    checks++; if (dc_phase !== 3'd6) begin errors++; $display("FAIL b2b_phase got %0d exp 6", dc_phase); end
    push_sweep(-1);
    collect(NCS, -1, 0, mc);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [VEC_W-1:0] v;
    logic lb;
    int mc, n;
    send_vector(5, 3'd2, 1'b0, v, lb);
    push_sweep(-1);
    collect(3, -1, 0, mc);
    n = 0;
    while (!(dc_load && dc_cs == 4'd3) && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL mid_reach_cs3 got cs %0d exp 3", dc_cs); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, dc_load, ws_load, dc_cs, dc_phase, res_valid, res_data, res_cs, res_last, err}
        !== {1'b1, 32'd0} || dc_d !== '0) begin
      errors++;
      $display("FAIL mid_reset got rdy %0b load %0b cs %0d ph %0d rv %0b exp rdy 1 others 0",
               in_ready, dc_load, dc_cs, dc_phase, res_valid);
    end
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    send_vector(6, 3'd4, 1'b0, v, lb);
    checks++; if (dc_cs !== 4'd0) begin errors++; $display("FAIL mid_restart_cs got %0d exp 0", dc_cs); end
    push_sweep(-1);
    collect(NCS, -1, 0, mc);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [VEC_W-1:0] v;
    logic lb;
    int mc;
    mute_cs = 2;
    send_vector(7, 3'd7, 1'b0, v, lb);
    push_sweep(2);
    collect(2, -1, 0, mc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_early got %0b exp 0", err); end
`ifdef DC_FEEDER_TIMEOUT_EN
    collect(NCS - 2, -1, 0, mc);
    checks++; if (mc != 15) begin errors++; $display("FAIL tmo_cycles got %0d exp 15", mc); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %0b exp 1", err); end
    @(negedge clk);
`else
    repeat (3) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (dc_load !== 1'b1 || dc_cs !== 4'd2 || res_valid !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_stall cyc %0d got load %0b cs %0d rv %0b err %0b exp 1/2/0/0",
                 i, dc_load, dc_cs, res_valid, err);
      end
    end
`endif
    mute_cs = -1;
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill_and_sweep();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
